// File: rtl/uart_word_assembler_pkg.sv
// Shared types and widths for the UART byte-to-word assembler.
package uart_word_assembler_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/uart_word_assembler_timeout_counter.sv
// Inter-byte idle counter: counts cycles while enabled without a clear and
// flags when the idle limit is reached. A limit of 0 never expires.
module uart_word_assembler_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear)
            cnt_d = '0;
        else if (cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_word_assembler.sv
// Packs a UART byte stream (LSB first) into 32-bit words with a valid/ready
// output and an inter-byte timeout that discards stale partial words.
module uart_word_assembler
    import uart_word_assembler_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [2:0]        byte_count,
    output logic              timeout_err
);

    localparam logic [2:0] LAST_SLOT = 3'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] asm_q, asm_d, asm_tmp;
    logic [WORD_W-1:0] word_out_q, word_out_d;
    logic [2:0]        byte_count_q, byte_count_d;
    logic              timeout_err_q, timeout_err_d;
    logic [4:0]        bit_lo;
    logic              byte_xfer, word_xfer, expired;

    assign byte_xfer = byte_valid & byte_ready;
    assign word_xfer = word_valid & word_ready;

    uart_word_assembler_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_COLLECT),
        .clear  (byte_xfer),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (byte_xfer) state_d = ST_COLLECT;
            ST_COLLECT: begin
                if (byte_xfer && byte_count_q == LAST_SLOT) state_d = ST_PRESENT;
                else if (!byte_xfer && expired)             state_d = ST_IDLE;
            end
            ST_PRESENT: if (word_xfer) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // byte_ready is gated by reset so nothing looks acceptable while reset is held.
    always_comb begin
        byte_ready = !reset && (state_q != ST_PRESENT);
        word_valid = (state_q == ST_PRESENT);
    end

    always_comb begin
        asm_d         = asm_q;
        word_out_d    = word_out_q;
        byte_count_d  = byte_count_q;
        timeout_err_d = 1'b0;
        bit_lo        = {byte_count_q[1:0], 3'b000};
        asm_tmp       = asm_q;
        asm_tmp[bit_lo +: BYTE_W] = byte_in;
        case (state_q)
            ST_IDLE: begin
                if (byte_xfer) begin
                    asm_d        = {{(WORD_W-BYTE_W){1'b0}}, byte_in};
                    byte_count_d = 3'd1;
                end
            end
            ST_COLLECT: begin
                if (byte_xfer) begin
                    if (byte_count_q == LAST_SLOT) begin
                        word_out_d   = asm_tmp;
                        asm_d        = '0;
                        byte_count_d = 3'(BYTES_PER_WORD);
                    end else begin
                        asm_d        = asm_tmp;
                        byte_count_d = byte_count_q + 3'd1;
                    end
                end else if (expired) begin
                    asm_d         = '0;
                    byte_count_d  = '0;
                    timeout_err_d = 1'b1;
                end
            end
            ST_PRESENT: if (word_xfer) byte_count_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q         <= '0;
            word_out_q    <= '0;
            byte_count_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            asm_q         <= asm_d;
            word_out_q    <= word_out_d;
            byte_count_q  <= byte_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign word_out    = word_out_q;
    assign byte_count  = byte_count_q;
    assign timeout_err = timeout_err_q;

endmodule
